// File: rtl/keycode_sender_if.sv
// keycode_sender_if: keypad digit link between the code sender and the lock
interface keycode_sender_if;
    logic [3:0] key;
    logic       key_valid;
    logic       key_ready;
    logic       locked;
    modport master (output key, key_valid, input key_ready, locked);
    modport slave  (input key, key_valid, output key_ready, locked);
endinterface

// File: rtl/keycode_sender.sv
// keycode_sender: sends a stored keypad code over a valid/ready link and reports the lock result
module keycode_sender #(
    parameter int MAX_LEN   = 8,
    parameter int GAP       = 2,
    parameter int RESP_WAIT = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(MAX_LEN)-1:0] wr_addr,
    input  logic [3:0]                 wr_data,
    input  logic                       len_ld,
    input  logic [$clog2(MAX_LEN):0]   len_val,
    input  logic                       start,
    keycode_sender_if.master           kif,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic                       err
);
    localparam int AW = $clog2(MAX_LEN);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(GAP + RESP_WAIT + 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP > 0 ? GAP - 1 : 0);
    localparam logic [CW-1:0] R_LAST = CW'(RESP_WAIT - 1);
    localparam logic [63:0] DEF_CODE = 64'h652533;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEND   = 3'd1;
    localparam logic [2:0] S_GAP    = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    logic [2:0]    state;
    logic [3:0]    code [MAX_LEN];
    logic [LW-1:0] len;
    logic [AW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          lock_s;
    logic          idle;
    logic          send;
    logic          last;
    logic          len_ok;

    assign idle          = state == S_IDLE;
    assign send          = state == S_SEND;
    assign last          = {1'b0, idx} == len - 1'b1;
    assign len_ok        = len_val != '0 && len_val <= LW'(MAX_LEN);
    assign busy          = !idle;
    assign kif.key_valid = send;
    assign kif.key       = send ? code[idx] : 4'd0;

    // code and length storage; commands only land while idle, anything rejected pulses err
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) code[i] <= DEF_CODE[i*4 +: 4];
            len <= LW'(MAX_LEN < 6 ? MAX_LEN : 6);
            err <= 1'b0;
        end else begin
            err <= (wr_en && (!idle || wr_data > 4'd9)) || (len_ld && (!idle || !len_ok));
            if (idle && wr_en && wr_data <= 4'd9) code[wr_addr] <= wr_data;
            if (idle && len_ld && len_ok) len <= len_val;
        end
    end

    // transmit sequencer: digits with gaps, response window, then a registered result
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            cnt    <= '0;
            lock_s <= 1'b1;
            done   <= 1'b0;
            pass   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    idx   <= '0;
                    pass  <= 1'b0;
                    state <= S_SEND;
                end
                S_SEND: if (kif.key_ready) begin
                    cnt <= '0;
                    if (last) state <= S_RESP;
                    else begin
                        idx   <= idx + 1'b1;
                        state <= GAP == 0 ? S_SEND : S_GAP;
                    end
                end
                S_GAP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == G_LAST) state <= S_SEND;
                end
                S_RESP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == R_LAST) begin
                        lock_s <= kif.locked;
                        state  <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    done  <= 1'b1;
                    pass  <= ~lock_s;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keycode_sender.sv
// tb_keycode_sender: directed scoreboard bench for keycode_sender
module tb_keycode_sender;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       len_ld = 1'b0;
    logic [3:0] len_val = '0;
    logic       start = 1'b0;
    logic       busy0, done0, pass0, err0;
    logic       busy1, done1, pass1, err1;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         n;
    int         dn;
    logic [3:0] exp_q[$];
    int         xfer_q[$];
    logic [23:0] rx_hist = '0;
    int         rx_n = 0;
    logic       rx_clr = 1'b0;

    keycode_sender_if kif0 ();
    keycode_sender_if kif1 ();

    keycode_sender #(.MAX_LEN(8), .GAP(2), .RESP_WAIT(3)) u0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len_ld(len_ld), .len_val(len_val), .start(start), .kif(kif0),
        .busy(busy0), .done(done0), .pass(pass0), .err(err0)
    );

    keycode_sender #(.MAX_LEN(8), .GAP(0), .RESP_WAIT(3)) u1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len_ld(len_ld), .len_val(len_val), .start(start), .kif(kif1),
        .busy(busy1), .done(done1), .pass(pass1), .err(err1)
    );

    always #5 clk = ~clk;

    assign kif0.locked    = !(rx_n == 6 && rx_hist == 24'h335256);
    assign kif1.key_ready = 1'b1;
    assign kif1.locked    = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_code(input logic [23:0] c);
        for (int i = 5; i >= 0; i--) exp_q.push_back(c[i*4 +: 4]);
    endtask

    task automatic begin_run();
        rx_clr = 1'b1;
        step();
        rx_clr = 1'b0;
        xfer_q.delete();
    endtask

    task automatic run(output int cnt);
        cnt = 0;
        step();
        cnt++;
        start = 1'b0;
        wr_en = 1'b0;
        check("busy_rise", busy0, 1);
        while (!done0 && cnt < 200) begin
            step();
            cnt++;
        end
        check("done_seen", done0, 1);
        check("busy_low_at_done", busy0, 0);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_clr) begin
            rx_n    <= 0;
            rx_hist <= '0;
        end else if (kif0.key_valid && kif0.key_ready) begin
            rx_hist <= {rx_hist[19:0], kif0.key};
            rx_n    <= rx_n + 1;
        end
    end

    always @(negedge clk) begin
        if (!reset && kif0.key_valid && kif0.key_ready) begin
            check("digit_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("digit", kif0.key, exp_q.pop_front());
            xfer_q.push_back(cyc);
        end
    end

    initial begin
        kif0.key_ready = 1'b1;
        step();
        step();
        check("rst_key_valid", kif0.key_valid, 0);
        check("rst_key", kif0.key, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_err", err0, 0);
        reset = 1'b0;

        begin_run();
        push_code(24'h335256);
        start = 1'b1;
        run(n);
        check("lat_default", n, 21);
        check("pass_default", pass0, 1);
        check("xfers_default", xfer_q.size(), 6);
        for (int i = 1; i < xfer_q.size(); i++) check("gap_spacing", xfer_q[i] - xfer_q[i-1], 3);
        check("queue_drained1", exp_q.size(), 0);
        step();
        check("done_one_cycle", done0, 0);
        check("pass_held", pass0, 1);

        begin_run();
        push_code(24'h337256);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'd7;
        start = 1'b1;
        run(n);
        check("lat_write_start", n, 21);
        check("pass_wrong_code", pass0, 0);
        check("queue_drained2", exp_q.size(), 0);

        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'd5;
        step();
        wr_en = 1'b0;
        check("err_good_write", err0, 0);
        begin_run();
        push_code(24'h335256);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (xfer_q.size() < 2 && n < 50) begin step(); n++; end
        kif0.key_ready = 1'b0;
        n = 0;
        while (!kif0.key_valid && n < 10) begin step(); n++; end
        for (int k = 0; k < 6; k++) begin
            check("stall_key", kif0.key, 5);
            check("stall_valid", kif0.key_valid, 1);
            step();
        end
        kif0.key_ready = 1'b1;
        n = 0;
        while (!done0 && n < 100) begin step(); n++; end
        check("stall_done", done0, 1);
        check("stall_pass", pass0, 1);
        check("stall_xfers", xfer_q.size(), 6);
        check("queue_drained3", exp_q.size(), 0);

        len_ld = 1'b1; len_val = 4'd0;
        step();
        check("err_len0", err0, 1);
        len_val = 4'd9;
        step();
        check("err_len9", err0, 1);
        len_ld = 1'b0;
        step();
        check("err_clears", err0, 0);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd12;
        step();
        wr_en = 1'b0;
        check("err_data12", err0, 1);
        begin_run();
        push_code(24'h335256);
        start = 1'b1;
        step();
        check("busy_cmd_phase", busy0, 1);
        step();
        check("err_start_busy", err0, 0);
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd9;
        step();
        check("err_write_busy", err0, 1);
        wr_en = 1'b0;
        len_ld = 1'b1; len_val = 4'd2;
        step();
        check("err_len_busy", err0, 1);
        len_ld = 1'b0;
        n = 0;
        while (!done0 && n < 100) begin step(); n++; end
        check("err_run_done", done0, 1);
        check("err_run_pass", pass0, 1);
        check("err_run_xfers", xfer_q.size(), 6);
        check("queue_drained4", exp_q.size(), 0);

        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'd7;
        step();
        wr_en = 1'b0;
        begin_run();
        exp_q.push_back(4'd3); exp_q.push_back(4'd3); exp_q.push_back(4'd7); exp_q.push_back(4'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (xfer_q.size() < 4 && n < 50) begin step(); n++; end
        check("abort_in_gap", kif0.key_valid, 0);
        reset = 1'b1;
        step();
        check("abort_valid", kif0.key_valid, 0);
        check("abort_busy", busy0, 0);
        reset = 1'b0;
        dn = 0;
        for (int k = 0; k < 30; k++) begin
            if (done0) dn++;
            step();
        end
        check("abort_no_done", dn, 0);
        check("abort_queue", exp_q.size(), 0);
        begin_run();
        push_code(24'h335256);
        start = 1'b1;
        run(n);
        check("lat_after_reset", n, 21);
        check("pass_after_reset", pass0, 1);
        check("queue_drained5", exp_q.size(), 0);

        len_ld = 1'b1; len_val = 4'd1;
        step();
        len_ld = 1'b0;
        check("err_len1", err0, 0);
        begin_run();
        exp_q.push_back(4'd3);
        start = 1'b1;
        n = 0;
        step();
        n++;
        start = 1'b0;
        while (!done1 && n < 50) begin
            if (kif1.key_valid) check("gap0_key", kif1.key, 3);
            step();
            n++;
        end
        check("gap0_done", done1, 1);
        check("gap0_lat", n, 6);
        check("gap0_pass", pass1, 0);
        check("len1_done_u0", done0, 1);
        check("len1_xfers", xfer_q.size(), 1);
        check("queue_drained6", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
